// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared obstacle encodings, sprite geometry and screen size
// Imported by the obstacle spawner and the per-pixel obstacle renderer.
// Contents: obstacle_sel_e (ObstacleSEL codes), gamestate_e, sprite sizes,
// BIRD_OFFSET, SCREEN_W/SCREEN_H, and the random-bits to obstacle-type mapping.
package obstacle_pkg;

    typedef enum logic [3:0] {
        SEL_CAC1S = 4'b0100,
        SEL_CAC1B = 4'b0101,
        SEL_CAC2S = 4'b0110,
        SEL_CAC2B = 4'b0111,
        SEL_BIRD  = 4'b1000
    } obstacle_sel_e;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_RUN   = 2'b01,
        GS_OVER  = 2'b10,
        GS_IDLE2 = 2'b11
    } gamestate_e;

    // Sprite widths
    localparam int CAC1S_W = 34;
    localparam int CAC2S_W = 68;
    localparam int CAC1B_W = 50;
    localparam int CAC2B_W = 100;
    localparam int BIRD_W  = 92;

    // Sprite heights
    localparam int CAC_S_H = 70;
    localparam int CAC_B_H = 100;
    localparam int BIRD_H  = 80;

    // ObstacleY for a bird is its sprite top minus this offset
    localparam int BIRD_OFFSET = 70;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Three random bits pick the obstacle type; birds get 3/8 of spawns.
    function automatic obstacle_sel_e sel_from_rand(input logic [2:0] r);
        case (r)
            3'd0, 3'd1: return SEL_CAC1S;
            3'd2:       return SEL_CAC2S;
            3'd3:       return SEL_CAC1B;
            3'd4:       return SEL_CAC2B;
            default:    return SEL_BIRD;
        endcase
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR, advances every clock out of reset
// Ports: clk, rst (async, active-high, loads SEED), lfsr (current state).
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ MASK;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - spawns, scrolls and retires one obstacle per frame
// Ports: clk, rst (async, active-high), frame_tick (1-clk per frame),
//        gamestate[1:0]; outputs ObstacleX[9:0], ObstacleY[9:0],
//        ObstacleSEL[3:0], BirdSEL, obstacle_cleared (1-clk pulse on retire).
// Optional: OBSTACLE_SPEEDUP_EN adds a cleared-obstacle counter that raises
// the scroll speed by one every SPEED_STEP_OBS clears, up to MAX_SPEED.
module obstacle_spawner
    import obstacle_pkg::*;
#(
    parameter int          GROUND_Y       = 400,
    parameter int          BASE_SPEED     = 4,
    parameter int          MIN_GAP        = 30,
    parameter int          WING_FRAMES    = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          SPEED_STEP_OBS = 8,
    parameter int          MAX_SPEED      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] gamestate,
    output logic [9:0] ObstacleX,
    output logic [9:0] ObstacleY,
    output logic [3:0] ObstacleSEL,
    output logic       BirdSEL,
    output logic       obstacle_cleared
);

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_ACTIVE, ST_FROZEN} state_e;

    localparam logic [9:0] PARK_X  = 10'(SCREEN_W);
    localparam logic [9:0] Y_LOW   = 10'(GROUND_Y - CAC_S_H);
    localparam logic [9:0] Y_TALL  = 10'(GROUND_Y - CAC_B_H);
    localparam logic [9:0] Y_BIRD0 = 10'(GROUND_Y - BIRD_H - BIRD_OFFSET);

    state_e        state;
    logic [9:0]    gap;
    logic [7:0]    wing_cnt;
    logic [9:0]    speed;
    logic [15:0]   lfsr;
    logic [9:0]    lift;
    logic [9:0]    spawn_y;
    obstacle_sel_e spawn_sel;
    logic [9:0]    rand_gap;
    logic          gs_idle;
    logic          unused_lfsr_bits;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr[15:6];
    assign gs_idle  = (gamestate == GS_IDLE) || (gamestate == GS_IDLE2);
    assign rand_gap = 10'(MIN_GAP) + {4'd0, lfsr[5:0]};

    always_comb begin
        case (lfsr[4:3])
            2'd0:    lift = 10'd0;
            2'd1:    lift = 10'd30;
            default: lift = 10'd60;
        endcase
        spawn_sel = sel_from_rand(lfsr[2:0]);
        case (spawn_sel)
            SEL_CAC1B, SEL_CAC2B: spawn_y = Y_TALL;
            SEL_BIRD:             spawn_y = Y_BIRD0 - lift;
            default:              spawn_y = Y_LOW;
        endcase
    end

`ifdef OBSTACLE_SPEEDUP_EN
    logic [7:0] clr_cnt;

    // Counts the registered clear pulse; speed only matters on ACTIVE ticks,
    // which can never fall in the cycle right after a retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed   <= 10'(BASE_SPEED);
            clr_cnt <= 8'd0;
        end else if (state == ST_IDLE || (state == ST_FROZEN && gamestate == GS_RUN)) begin
            speed   <= 10'(BASE_SPEED);
            clr_cnt <= 8'd0;
        end else if (obstacle_cleared) begin
            if (clr_cnt == 8'(SPEED_STEP_OBS - 1)) begin
                clr_cnt <= 8'd0;
                if (speed < 10'(MAX_SPEED)) begin
                    speed <= speed + 10'd1;
                end
            end else begin
                clr_cnt <= clr_cnt + 8'd1;
            end
        end
    end
`else
    localparam int UNUSED_SPEEDUP_CFG = SPEED_STEP_OBS + MAX_SPEED;
    assign speed = 10'(BASE_SPEED);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            gap              <= 10'(MIN_GAP);
            wing_cnt         <= 8'd0;
            ObstacleX        <= PARK_X;
            ObstacleY        <= Y_LOW;
            ObstacleSEL      <= SEL_CAC1S;
            BirdSEL          <= 1'b0;
            obstacle_cleared <= 1'b0;
        end else begin
            obstacle_cleared <= 1'b0;
            // Leaving the run (idle or 11) always wins over any frame_tick.
            if (gs_idle) begin
                state       <= ST_IDLE;
                gap         <= 10'(MIN_GAP);
                wing_cnt    <= 8'd0;
                ObstacleX   <= PARK_X;
                ObstacleY   <= Y_LOW;
                ObstacleSEL <= SEL_CAC1S;
                BirdSEL     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (gamestate == GS_RUN && frame_tick) begin
                            gap   <= rand_gap;
                            state <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (gamestate == GS_OVER) begin
                            state <= ST_FROZEN;
                        end else if (frame_tick) begin
                            if (gap == 10'd0) begin
                                ObstacleX   <= PARK_X;
                                ObstacleY   <= spawn_y;
                                ObstacleSEL <= spawn_sel;
                                BirdSEL     <= 1'b0;
                                wing_cnt    <= 8'd0;
                                state       <= ST_ACTIVE;
                            end else begin
                                gap <= gap - 10'd1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (gamestate == GS_OVER) begin
                            state <= ST_FROZEN;
                        end else if (frame_tick) begin
                            // Compare before subtract so X can never wrap.
                            if (ObstacleX < speed) begin
                                ObstacleX        <= PARK_X;
                                obstacle_cleared <= 1'b1;
                                gap              <= rand_gap;
                                state            <= ST_GAP;
                            end else begin
                                ObstacleX <= ObstacleX - speed;
                                if (ObstacleSEL == SEL_BIRD) begin
                                    if (wing_cnt == 8'(WING_FRAMES - 1)) begin
                                        wing_cnt <= 8'd0;
                                        BirdSEL  <= ~BirdSEL;
                                    end else begin
                                        wing_cnt <= wing_cnt + 8'd1;
                                    end
                                end
                            end
                        end
                    end
                    ST_FROZEN: begin
                        if (gamestate == GS_RUN) begin
                            gap         <= 10'(MIN_GAP);
                            wing_cnt    <= 8'd0;
                            ObstacleX   <= PARK_X;
                            ObstacleY   <= Y_LOW;
                            ObstacleSEL <= SEL_CAC1S;
                            BirdSEL     <= 1'b0;
                            state       <= ST_GAP;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb/tb_obstacle_spawner.sv - randomized bench with a behavioural obstacle model
module tb_obstacle_spawner;

    localparam int          GROUND_Y       = 400;
    localparam int          BASE_SPEED     = 4;
    localparam int          MIN_GAP        = 30;
    localparam int          WING_FRAMES    = 8;
    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    localparam int          SPEED_STEP_OBS = 8;
    localparam int          MAX_SPEED      = 12;

    localparam int S_IDLE = 0, S_GAP = 1, S_ACTIVE = 2, S_FROZEN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [1:0] gamestate;
    logic [9:0] ObstacleX;
    logic [9:0] ObstacleY;
    logic [3:0] ObstacleSEL;
    logic       BirdSEL;
    logic       obstacle_cleared;

    int vectors = 0;
    int miscompares = 0;

    obstacle_spawner #(
        .GROUND_Y(GROUND_Y), .BASE_SPEED(BASE_SPEED), .MIN_GAP(MIN_GAP),
        .WING_FRAMES(WING_FRAMES), .LFSR_SEED(LFSR_SEED),
        .SPEED_STEP_OBS(SPEED_STEP_OBS), .MAX_SPEED(MAX_SPEED)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamestate(gamestate),
        .ObstacleX(ObstacleX), .ObstacleY(ObstacleY), .ObstacleSEL(ObstacleSEL),
        .BirdSEL(BirdSEL), .obstacle_cleared(obstacle_cleared)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_state, m_x, m_y, m_sel, m_bsel, m_clr, m_gap, m_clears, m_ticks, m_bird;
    logic [15:0] m_lfsr;
    int sel_tab[8]  = '{4, 4, 6, 5, 7, 8, 8, 8};
    int lift_tab[4] = '{0, 30, 60, 60};

    function automatic int model_speed(input int clears);
`ifdef OBSTACLE_SPEEDUP_EN
        int s;
        s = BASE_SPEED + clears / SPEED_STEP_OBS;
        return (s > MAX_SPEED) ? MAX_SPEED : s;
`else
        return BASE_SPEED + 0 * clears;
`endif
    endfunction

    task automatic model_park();
        m_x = 640; m_y = GROUND_Y - 70; m_sel = 4; m_bsel = 0; m_bird = 0;
    endtask

    always @(posedge clk or posedge rst) begin : model
        logic [15:0] lf;
        int r, spd;
        if (rst) begin
            m_state = S_IDLE; model_park(); m_clr = 0; m_gap = MIN_GAP;
            m_clears = 0; m_ticks = 0; m_lfsr = LFSR_SEED;
        end else begin
            lf = m_lfsr;
            m_clr = 0;
            if (gamestate == 2'd0 || gamestate == 2'd3) begin
                m_state = S_IDLE; model_park(); m_gap = MIN_GAP; m_clears = 0;
            end else begin
                case (m_state)
                    S_IDLE: if (gamestate == 2'd1 && frame_tick) begin
                        m_gap = MIN_GAP + int'(lf[5:0]); m_state = S_GAP;
                    end
                    S_GAP: if (gamestate == 2'd2) m_state = S_FROZEN;
                    else if (frame_tick) begin
                        if (m_gap == 0) begin
                            r = int'(lf[2:0]);
                            m_sel = sel_tab[r];
                            m_bird = (r >= 5) ? 1 : 0;
                            if (r <= 2) m_y = GROUND_Y - 70;
                            else if (r <= 4) m_y = GROUND_Y - 100;
                            else m_y = GROUND_Y - 80 - lift_tab[lf[4:3]] - 70;
                            m_x = 640; m_bsel = 0; m_ticks = 0; m_state = S_ACTIVE;
                        end else m_gap--;
                    end
                    S_ACTIVE: if (gamestate == 2'd2) m_state = S_FROZEN;
                    else if (frame_tick) begin
                        spd = model_speed(m_clears);
                        if (m_x < spd) begin
                            m_x = 640; m_clr = 1; m_clears++;
                            m_gap = MIN_GAP + int'(lf[5:0]); m_state = S_GAP;
                        end else begin
                            m_x -= spd;
                            if (m_bird != 0) begin
                                m_ticks++;
                                m_bsel = (m_ticks / WING_FRAMES) % 2;
                            end
                        end
                    end
                    default: if (gamestate == 2'd1) begin
                        model_park(); m_clears = 0; m_gap = MIN_GAP; m_state = S_GAP;
                    end
                endcase
            end
            m_lfsr = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("x", int'(ObstacleX), m_x);
            check("y", int'(ObstacleY), m_y);
            check("sel", int'(ObstacleSEL), m_sel);
            check("birdsel", int'(BirdSEL), m_bsel);
            check("cleared", int'(obstacle_cleared), m_clr);
            if (ObstacleSEL == 4'b0101) check("pin_cac1b_y", int'(ObstacleY), 300);
            if (ObstacleSEL == 4'b1000) begin
                vectors++;
                if (ObstacleY != 10'd250 && ObstacleY != 10'd220 && ObstacleY != 10'd190) begin
                    miscompares++;
                    $display("FAIL pin_bird_y: got %0d expected 250/220/190", ObstacleY);
                end
            end
            if (obstacle_cleared) check("pin_clr_x", int'(ObstacleX), 640);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n, input int tick_pct, input int gs_permille);
        int r;
        repeat (n) begin
            @(negedge clk);
            frame_tick = ($urandom_range(99) < tick_pct);
            if ($urandom_range(999) < gs_permille) begin
                r = $urandom_range(9);
                gamestate = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 4) ? 2'd2 : 2'd1;
            end
        end
    endtask

    task automatic wait_active(input int xmax, input string name);
        int n;
        n = 0;
        gamestate = 2'd1;
        forever begin
            @(negedge clk);
            if (m_state == S_ACTIVE && m_x <= xmax) begin
                frame_tick = 1'b0;
                break;
            end
            frame_tick = $urandom_range(1);
            n++;
            if (n > 20000) begin
                vectors++; miscompares++;
                $display("FAIL %s: no ACTIVE with X<=%0d within budget", name, xmax);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; gamestate = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_x", int'(ObstacleX), 640);
        check("rst_y", int'(ObstacleY), 330);
        check("rst_sel", int'(ObstacleSEL), 4);
        check("rst_birdsel", int'(BirdSEL), 0);
        check("rst_cleared", int'(obstacle_cleared), 0);
        rst = 1'b0;
        gamestate = 2'd1;

        run(12000, 50, 0);

        // freeze mid-screen for 100 ticks, then restart
        wait_active(300, "freeze_wait");
        gamestate = 2'd2;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            frame_tick = i[0];
        end
        @(negedge clk);
        frame_tick = 1'b0;
        gamestate = 2'd1;
        @(negedge clk);
        check("pin_restart_park", int'(ObstacleX), 640);
        for (int t = 1; t <= 32; t++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            if (t == 30) check("pin_restart_gap_x", int'(ObstacleX), 640);
            if (t == 31) check("pin_restart_spawn_x", int'(ObstacleX), 640);
            if (t == 32) check("pin_restart_move_x", int'(ObstacleX), 636);
            @(negedge clk);
        end

        // idle via 00 and 11, then resume
        gamestate = 2'd0; run(20, 50, 0);
        gamestate = 2'd3; run(20, 50, 0);
        gamestate = 2'd1;
        run(8000, 50, 3);

        // asynchronous reset while an obstacle is on screen
        wait_active(200, "reset_wait");
        #2 rst = 1'b1;
        #1;
        check("arst_x", int'(ObstacleX), 640);
        check("arst_sel", int'(ObstacleSEL), 4);
        check("arst_birdsel", int'(BirdSEL), 0);
        check("arst_y", int'(ObstacleY), 330);
        @(negedge clk);
        rst = 1'b0;
        gamestate = 2'd1;
        run(3000, 50, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
